// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_t      : responder FSM states
//   LAT_W        : width of the latency down-counter
//   *_LAT_DEF    : default read/write latencies
//   lat_ok()     : legal-latency predicate used for the elaboration-time check
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int LAT_W      = 4;
  localparam int RD_LAT_DEF = 3;
  localparam int WR_LAT_DEF = 2;

  // Latency must fit the counter and be at least one cycle.
  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= (1 << LAT_W) - 1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory handshake bundle.
//   master : pipeline side (drives req_*, observes ready/stall/done/rdata)
//   slave  : responder side
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, stall, done, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, stall, done, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word array, 2^DEPTH_LOG2 x DATA_W.
//   clk   : clock
//   en    : access enable (nothing happens when low)
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; holds until the next enabled read
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_if.slave -- one request at a time; stall holds the
//              pipeline until done pulses for one cycle (load data on
//              rsp_rdata in that cycle and held until the next load).
// Accept at cycle t gives done at t+LAT; the array is accessed on the edge
// entering DONE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int WR_LAT     = WR_LAT_DEF
) (
  input logic    clk,
  input logic    rst,
  dmem_if.slave  bus
);

  if (!lat_ok(RD_LAT) || !lat_ok(WR_LAT)) begin : g_bad_lat
    $error("dmem_responder: RD_LAT/WR_LAT must be in 1..15");
  end

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  rsp_vld_q;

  logic                  accept;
  logic [LAT_W-1:0]      req_lat;
  logic                  commit;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [DATA_W-1:0]     arr_wdata;
  logic [DATA_W-1:0]     arr_rdata;

  // Upper address bits are intentionally ignored (addresses alias).
  if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2];
  end

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign req_lat = bus.req_wr ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_lat > LAT_W'(1)) ? ACCESS : DONE;
      ACCESS:  if (cnt_q == LAT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.stall     = accept || (state_q == ACCESS);
    bus.done      = (state_q == DONE);
  end

  // Array access fires on the edge entering DONE. With LAT=1 that edge is
  // the accept edge itself, so the request fields come straight from the bus
  // instead of the (not yet loaded) latches. Reset suppresses the access so
  // an in-flight write is dropped.
  assign commit    = !rst && (state_q != DONE) && (state_d == DONE);
  assign arr_we    = commit && ((state_q == IDLE) ? bus.req_wr : wr_q);
  assign arr_addr  = (state_q == IDLE) ? bus.req_addr[DEPTH_LOG2-1:0] : addr_q;
  assign arr_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      if (accept)                  cnt_q <= req_lat - LAT_W'(1);
      else if (state_q == ACCESS)  cnt_q <= cnt_q - LAT_W'(1);
      if (commit && !arr_we)       rsp_vld_q <= 1'b1;
    end
  end

  // Request latches; only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.req_wr;
      addr_q  <= bus.req_addr[DEPTH_LOG2-1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // The array's read register only updates on reads, so it already holds
  // across writes; rsp_vld_q forces zero until the first load after reset.
  assign bus.rsp_rdata = rsp_vld_q ? arr_rdata : '0;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  dmem_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  dmem_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .RD_LAT(3), .WR_LAT(2))
    u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .RD_LAT(1), .WR_LAT(1))
    u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs set and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on DUT A starting in an IDLE cycle. req_valid stays
  // high through DONE (the old request) and drops in the following IDLE cycle.
  task automatic a_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input int lat, input logic [15:0] exp, input bit churn);
    bus_a.req_valid = 1'b1; bus_a.req_wr = wr;
    bus_a.req_addr  = addr; bus_a.req_wdata = wd;
    #1;
    chk("a_acc_stall", 32'(bus_a.stall), 32'd1);
    chk("a_acc_ready", 32'(bus_a.req_ready), 32'd1);
    chk("a_acc_done",  32'(bus_a.done), 32'd0);
    for (int k = 1; k < lat; k++) begin
      step();
      if (churn) begin
        bus_a.req_addr  = 16'h0030 + 16'(k);
        bus_a.req_wdata = 16'h5A5A;
      end
      chk("a_wait_stall", 32'(bus_a.stall), 32'd1);
      chk("a_wait_done",  32'(bus_a.done), 32'd0);
      chk("a_wait_ready", 32'(bus_a.req_ready), 32'd0);
    end
    step();
    chk("a_done",       32'(bus_a.done), 32'd1);
    chk("a_done_stall", 32'(bus_a.stall), 32'd0);
    if (!wr) last_rd = exp;
    chk(wr ? "a_wr_hold_rdata" : "a_rdata", 32'(bus_a.rsp_rdata), 32'(last_rd));
    step();
    bus_a.req_valid = 1'b0;
    #1;
    chk("a_post_done",  32'(bus_a.done), 32'd0);
    chk("a_post_ready", 32'(bus_a.req_ready), 32'd1);
  endtask

  // Single-cycle-latency transaction on DUT B; back-to-back calls give one
  // request every 2 cycles.
  task automatic b_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp);
    bus_b.req_valid = 1'b1; bus_b.req_wr = wr;
    bus_b.req_addr  = addr; bus_b.req_wdata = wd;
    #1;
    chk("b_acc_stall", 32'(bus_b.stall), 32'd1);
    chk("b_acc_done",  32'(bus_b.done), 32'd0);
    step();
    chk("b_done",       32'(bus_b.done), 32'd1);
    chk("b_done_stall", 32'(bus_b.stall), 32'd0);
    chk("b_done_ready", 32'(bus_b.req_ready), 32'd0);
    if (!wr) chk("b_rdata", 32'(bus_b.rsp_rdata), 32'(exp));
    step();
    bus_b.req_valid = 1'b0;
    #1;
    chk("b_post_done", 32'(bus_b.done), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_wr = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_wr = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    last_rd = 16'h0000;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_ready", 32'(bus_a.req_ready), 32'd1);
    chk("rst_stall", 32'(bus_a.stall), 32'd0);
    chk("rst_done",  32'(bus_a.done), 32'd0);
    chk("rst_rdata", 32'(bus_a.rsp_rdata), 32'h0000);
    step();
    chk("idle_stall", 32'(bus_a.stall), 32'd0);

    // Store then load
    a_req(1'b1, 16'h0005, 16'hBEEF, 2, 16'h0, 1'b0);
    a_req(1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b0);

    // Alias: 0x0400 maps onto 0x0000
    a_req(1'b1, 16'h0400, 16'h1234, 2, 16'h0, 1'b0);
    a_req(1'b0, 16'h0000, 16'h0000, 3, 16'h1234, 1'b0);

    // Input churn during a store's ACCESS cycle
    a_req(1'b1, 16'h0031, 16'h0F0F, 2, 16'h0, 1'b0);
    a_req(1'b1, 16'h0010, 16'hAAAA, 2, 16'h0, 1'b1);
    a_req(1'b0, 16'h0010, 16'h0000, 3, 16'hAAAA, 1'b0);
    a_req(1'b0, 16'h0031, 16'h0000, 3, 16'h0F0F, 1'b0);

    // Reset during a write's ACCESS cycle
    a_req(1'b1, 16'h0020, 16'h0000, 2, 16'h0, 1'b0);
    bus_a.req_valid = 1'b1; bus_a.req_wr = 1'b1;
    bus_a.req_addr  = 16'h0020; bus_a.req_wdata = 16'h5555;
    #1;
    chk("rw_acc_stall", 32'(bus_a.stall), 32'd1);
    step();
    chk("rw_access_stall", 32'(bus_a.stall), 32'd1);
    rst_a = 1'b1;
    bus_a.req_valid = 1'b0;
    step();
    rst_a = 1'b0;
    last_rd = 16'h0000;
    #1;
    chk("rw_no_done",  32'(bus_a.done), 32'd0);
    chk("rw_ready",    32'(bus_a.req_ready), 32'd1);
    chk("rw_rdata_clr", 32'(bus_a.rsp_rdata), 32'h0000);
    step();
    chk("rw_no_done2", 32'(bus_a.done), 32'd0);
    a_req(1'b0, 16'h0020, 16'h0000, 3, 16'h0000, 1'b0);

    // Latency-1 build: back-to-back every 2 cycles
    b_req(1'b1, 16'h0003, 16'h1111, 16'h0);
    b_req(1'b1, 16'h0004, 16'h2222, 16'h0);
    b_req(1'b0, 16'h0003, 16'h0000, 16'h1111);
    b_req(1'b0, 16'h0004, 16'h0000, 16'h2222);
    b_req(1'b1, 16'h0403, 16'h3333, 16'h0);
    b_req(1'b0, 16'h0003, 16'h0000, 16'h3333);
    step();
    chk("b_idle_stall", 32'(bus_b.stall), 32'd0);
    chk("b_hold_rdata", 32'(bus_b.rsp_rdata), 32'h3333);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU pipeline's MEM-stage read/write requests.
- Replaces the ideal single-cycle data memory with a fixed-latency, multi-cycle memory.
- Accepts one request at a time and holds the pipeline with `stall` until the access completes.
- Returns read data with a one-cycle `done` pulse; the pipeline advances on that cycle.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, request address width
- DEPTH_LOG2, 10, log2 of implemented words; address bits above this are ignored
- RD_LAT, 3, cycles from accept to `done` for reads; legal range 1..15
- WR_LAT, 2, cycles from accept to `done` for writes; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage has a load or store; held stable while `stall`=1
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  responder can accept a request this cycle (IDLE only)
- stall  out  1  freeze all pipeline enables this cycle
- done  out  1  one-cycle pulse: access complete
- rsp_rdata  out  DATA_W  load data, valid when `done`=1 on a read

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset is synchronous, active-high on `rst`.
  - Reset values: state=IDLE, counter=0, rsp_rdata=0, done=0, req_ready=1, stall=req_valid (combinational).
  - Array contents are not reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - If req_valid=1: accept. Latch wr, addr[DEPTH_LOG2-1:0] and wdata; load counter=LAT-1, where LAT = RD_LAT or WR_LAT by req_wr.
  - Next state is ACCESS if LAT>1, else DONE.
  - If req_valid=0: remain in IDLE.
- ACCESS:
  - Decrement counter each cycle; go to DONE when counter reaches 1.
  - Inputs are ignored; latched fields are authoritative.
- DONE:
  - done=1 for exactly this one cycle; then go to IDLE unconditionally.
  - A req_valid present in DONE is not accepted; it is the old, still-asserted request and the pipeline advances at this edge.
- Latency: accept at cycle t means done=1 at cycle t+LAT.
- stall:
  - stall = (state==IDLE & req_valid) | (state==ACCESS).
  - stall=0 in DONE and when idle with no request.
- Write commit: the array is written on the clock edge entering DONE, i.e. visible to any read accepted from t+LAT+1 onward.
- Read capture: the array is read with the latched address on the edge entering DONE; rsp_rdata is registered then.
- rsp_rdata: holds its value until the next read completes; writes do not change it.
- Address: wraps modulo 2^DEPTH_LOG2, so addresses 0x0400 and 0x0000 alias when DEPTH_LOG2=10.
- Reset mid-operation: any state returns to IDLE next cycle. A write not yet committed is dropped; done is not pulsed.
- Back-to-back requests: minimum spacing is LAT+1 cycles (accept, LAT-1 ACCESS cycles, DONE, new accept in IDLE).
- hlt: has no effect here; the halt flag propagates through the pipeline independently.

Decomposition:
- Shared package `dmem_pkg`:
  - state enum {IDLE, ACCESS, DONE}
  - LAT_W=4 counter width
  - default latency constants
  - an elaboration-time check that 1<=RD_LAT,WR_LAT<=15
- Sub-module `dmem_array`: 2^DEPTH_LOG2 x DATA_W, synchronous write, synchronous read, single port (we, addr, wdata, rdata).
- The FSM, counter and response register stay in dmem_responder.

Test Plan:
- Reset check: assert rst for 2 cycles with req_valid=0 -> req_ready=1, stall=0, done=0, rsp_rdata=0x0000.
- Store then load: store addr=0x0005, data=0xBEEF accepted at t0 -> stall=1 at t0..t1, done=1 at t2. Load addr=0x0005 accepted at t3 -> stall t3..t5, done=1 at t6 with rsp_rdata=0xBEEF.
- Alias: store 0x1234 to addr 0x0400, then load addr 0x0000 -> rsp_rdata=0x1234.
- Input churn: change req_addr and req_wdata every cycle during ACCESS of a store to 0x0010 with data 0xAAAA -> only 0x0010 is written, with 0xAAAA (read back to confirm).
- Reset during write: store 0x5555 to addr 0x0020 (old value 0x0000), assert rst in the ACCESS cycle -> no done pulse; later load of 0x0020 returns 0x0000.
- Latency sweep: RD_LAT=1 and WR_LAT=1 build -> done exactly 1 cycle after accept, stall only in the accept cycle, and back-to-back loads every 2 cycles return correct data.
